// File: rtl/vdiv_elem_seq_if.sv
// Handshake bundle between the vector divide lane, the element
// sequencer and the serial divider.
interface vdiv_elem_seq_if;
    logic [63:0] op_a_i;
    logic [63:0] op_b_i;
    logic [1:0]  opcode_i;
    logic [1:0]  sew_i;
    logic [7:0]  be_i;
    logic        in_vld_i;
    logic        in_rdy_o;
    logic        flush_i;
    logic        div_vld_o;
    logic        div_rdy_i;
    logic [63:0] div_op_a_o;
    logic [63:0] div_op_b_o;
    logic [1:0]  div_opcode_o;
    logic        div_res_vld_i;
    logic        div_res_rdy_o;
    logic [63:0] div_res_i;
    logic        div_flush_o;
    logic        out_vld_o;
    logic        out_rdy_i;
    logic [63:0] res_o;

    modport slave (
        input  op_a_i, op_b_i, opcode_i, sew_i, be_i, in_vld_i,
        output in_rdy_o,
        input  flush_i,
        output div_vld_o,
        input  div_rdy_i,
        output div_op_a_o, div_op_b_o, div_opcode_o,
        input  div_res_vld_i,
        output div_res_rdy_o,
        input  div_res_i,
        output div_flush_o, out_vld_o,
        input  out_rdy_i,
        output res_o
    );

    modport master (
        output op_a_i, op_b_i, opcode_i, sew_i, be_i, in_vld_i,
        input  in_rdy_o,
        output flush_i,
        input  div_vld_o,
        output div_rdy_i,
        input  div_op_a_o, div_op_b_o, div_opcode_o,
        output div_res_vld_i,
        input  div_res_rdy_o,
        output div_res_i,
        input  div_flush_o, out_vld_o,
        output out_rdy_i,
        input  res_o
    );
endinterface

// File: rtl/vdiv_elem_seq.sv
// Splits a packed 64-bit lane word into SEW elements, feeds them one at
// a time to the serial divider and repacks the truncated results.
module vdiv_elem_seq (
    input logic            clk_i,
    input logic            rst_ni,
    vdiv_elem_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

    state_e      state_q, state_d;
    logic [63:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [1:0]  opc_q, opc_d, sew_q, sew_d;
    logic [7:0]  be_q, be_d;
    logic [2:0]  idx_q, idx_d;

    logic [63:0] ext_a, ext_b;
    logic [2:0]  bpos;
    logic        act, last;
    logic        in_rdy, div_vld, res_rdy, out_vld;

    function automatic logic [63:0] ext(
        input logic [63:0] w,
        input logic [1:0]  sew,
        input logic [2:0]  idx,
        input logic        sgn
    );
        logic [7:0]  e8;
        logic [15:0] e16;
        logic [31:0] e32;
        logic [63:0] r;
        e8  = w[{idx, 3'b000} +: 8];
        e16 = w[{idx[1:0], 4'b0000} +: 16];
        e32 = w[{idx[0], 5'b00000} +: 32];
        unique case (sew)
            2'd0:    r = {{56{sgn & e8[7]}}, e8};
            2'd1:    r = {{48{sgn & e16[15]}}, e16};
            2'd2:    r = {{32{sgn & e32[31]}}, e32};
            default: r = w;
        endcase
        return r;
    endfunction

    // Operands come straight from the word registers, so they hold
    // steady for as long as the issue is stalled.
    assign ext_a = ext(a_q, sew_q, idx_q, opc_q[0]);
    assign ext_b = ext(b_q, sew_q, idx_q, opc_q[0]);
    assign bpos  = idx_q << sew_q;
    assign act   = be_q[bpos];
    assign last  = (idx_q == (3'd7 >> sew_q));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        opc_d   = opc_q;
        sew_d   = sew_q;
        be_d    = be_q;
        res_d   = res_q;
        idx_d   = idx_q;
        in_rdy  = 1'b0;
        div_vld = 1'b0;
        res_rdy = 1'b0;
        out_vld = 1'b0;
        if (bus.flush_i) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    in_rdy = 1'b1;
                    if (bus.in_vld_i) begin
                        a_d     = bus.op_a_i;
                        b_d     = bus.op_b_i;
                        opc_d   = bus.opcode_i;
                        sew_d   = bus.sew_i;
                        be_d    = bus.be_i;
                        res_d   = '0;
                        idx_d   = '0;
                        state_d = ISSUE;
                    end
                end
                ISSUE: begin
                    if (act) begin
                        div_vld = 1'b1;
                        if (bus.div_rdy_i) state_d = WAIT;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = last ? DONE : ISSUE;
                    end
                end
                WAIT: begin
                    res_rdy = 1'b1;
                    if (bus.div_res_vld_i) begin
                        unique case (sew_q)
                            2'd0: res_d[{idx_q, 3'b000} +: 8] = bus.div_res_i[7:0];
                            2'd1: res_d[{idx_q[1:0], 4'b0000} +: 16] = bus.div_res_i[15:0];
                            2'd2: res_d[{idx_q[0], 5'b00000} +: 32] = bus.div_res_i[31:0];
                            default: res_d = bus.div_res_i;
                        endcase
                        idx_d   = idx_q + 3'd1;
                        state_d = last ? DONE : ISSUE;
                    end
                end
                DONE: begin
                    out_vld = 1'b1;
                    if (bus.out_rdy_i) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            opc_q   <= '0;
            sew_q   <= '0;
            be_q    <= '0;
            res_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            opc_q   <= opc_d;
            sew_q   <= sew_d;
            be_q    <= be_d;
            res_q   <= res_d;
            idx_q   <= idx_d;
        end
    end

    assign bus.in_rdy_o      = in_rdy;
    assign bus.div_vld_o     = div_vld;
    assign bus.div_res_rdy_o = res_rdy;
    assign bus.out_vld_o     = out_vld;
    assign bus.div_op_a_o    = ext_a;
    assign bus.div_op_b_o    = ext_b;
    assign bus.div_opcode_o  = opc_q;
    assign bus.div_flush_o   = bus.flush_i;
    assign bus.res_o         = res_q;
endmodule

// File: tb/tb_vdiv_elem_seq.sv
// Directed bench for vdiv_elem_seq with a behavioural serial divider
// of programmable latency.
module tb_vdiv_elem_seq;
    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk = ~clk;

    vdiv_elem_seq_if bus ();

    vdiv_elem_seq dut (
        .clk_i (clk),
        .rst_ni(rst_ni),
        .bus   (bus.slave)
    );

    int total = 0;
    int bad = 0;

    logic        pend;
    int          cnt;
    logic [63:0] mres;
    int          issues;
    int          lat = 0;
    logic        rdy_en = 1'b1;
    logic        mdl_clear = 1'b0;

    function automatic logic [63:0] ref_div(
        input logic [63:0] a, input logic [63:0] b, input logic [1:0] op
    );
        logic [63:0] r;
        if (b == 64'd0) r = op[1] ? a : '1;
        else if (op[0] && a == 64'h8000_0000_0000_0000 && b == '1)
            r = op[1] ? 64'd0 : a;
        else if (op[0]) r = op[1] ? $signed(a) % $signed(b) : $signed(a) / $signed(b);
        else r = op[1] ? a % b : a / b;
        return r;
    endfunction

    assign bus.div_rdy_i     = rdy_en & ~pend;
    assign bus.div_res_vld_i = pend && (cnt == 0);
    assign bus.div_res_i     = mres;

    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            pend   <= 1'b0;
            cnt    <= 0;
            mres   <= '0;
            issues <= 0;
        end else if (mdl_clear) begin
            pend <= 1'b0;
        end else if (bus.div_vld_o && bus.div_rdy_i) begin
            pend   <= 1'b1;
            cnt    <= lat;
            mres   <= ref_div(bus.div_op_a_o, bus.div_op_b_o, bus.div_opcode_o);
            issues <= issues + 1;
        end else if (pend && cnt != 0) begin
            cnt <= cnt - 1;
        end else if (pend && bus.div_res_rdy_o) begin
            pend <= 1'b0;
        end
    end

    task automatic start_word(input logic [63:0] a, input logic [63:0] b,
                              input logic [1:0] op, input logic [1:0] sew,
                              input logic [7:0] be);
        @(negedge clk);
        bus.op_a_i   = a;
        bus.op_b_i   = b;
        bus.opcode_i = op;
        bus.sew_i    = sew;
        bus.be_i     = be;
        bus.in_vld_i = 1'b1;
        @(negedge clk);
        bus.in_vld_i = 1'b0;
    endtask

    task automatic run_word(input logic [63:0] a, input logic [63:0] b,
                            input logic [1:0] op, input logic [1:0] sew,
                            input logic [7:0] be,
                            output logic [63:0] res, output int cyc);
        start_word(a, b, op, sew, be);
        cyc = 1;
        while (!bus.out_vld_o && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        total++;
        if (bus.out_vld_o !== 1'b1) begin
            bad++;
            $display("FAIL word_timeout out_vld=%b required 1", bus.out_vld_o);
        end
        res = bus.res_o;
        bus.out_rdy_i = 1'b1;
        @(negedge clk);
        bus.out_rdy_i = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        total++;
        if ({bus.in_rdy_o, bus.div_vld_o, bus.div_res_rdy_o, bus.out_vld_o} !== 4'b1000) begin
            bad++;
            $display("FAIL reset_hs got=%b required 1000",
                     {bus.in_rdy_o, bus.div_vld_o, bus.div_res_rdy_o, bus.out_vld_o});
        end
        total++;
        if ({bus.res_o, bus.div_op_a_o, bus.div_op_b_o, bus.div_opcode_o} !== '0) begin
            bad++;
            $display("FAIL reset_data res=%h a=%h b=%h opc=%h required 0", bus.res_o,
                     bus.div_op_a_o, bus.div_op_b_o, bus.div_opcode_o);
        end
        @(negedge clk);
        rst_ni = 1'b1;
    endtask

    task automatic test_udiv8();
        logic [63:0] r;
        int c;
        int i0;
        i0 = issues;
        run_word(64'h6450_3C28_140A_0806, 64'h0A05_0302_0102_0403, 2'd0, 2'd0, 8'hFF, r, c);
        total++;
        if (r !== 64'h0A10_1414_1405_0202) begin
            bad++;
            $display("FAIL udiv8_res got=%h required 0a10141414050202", r);
        end
        total++;
        if (issues - i0 != 8) begin
            bad++;
            $display("FAIL udiv8_issues got=%0d required 8", issues - i0);
        end
        total++;
        if (c != 17) begin
            bad++;
            $display("FAIL udiv8_latency got=%0d required 17", c);
        end
    endtask

    task automatic test_div16();
        logic [63:0] r;
        int c;
        run_word(64'h8000_FFF9_0007_0010, 64'hFFFF_0002_0000_FFFC, 2'd1, 2'd1, 8'hFF, r, c);
        total++;
        if (r !== 64'h8000_FFFD_FFFF_FFFC) begin
            bad++;
            $display("FAIL div16_res got=%h required 8000fffdfffffffc", r);
        end
    endtask

    task automatic test_rem32();
        logic [63:0] r;
        int c;
        run_word(64'hFFFF_FFF9_0000_0007, 64'h0000_0002_0000_0000, 2'd3, 2'd2, 8'hFF, r, c);
        total++;
        if (r !== 64'hFFFF_FFFF_0000_0007) begin
            bad++;
            $display("FAIL rem32_res got=%h required ffffffff00000007", r);
        end
    endtask

    task automatic test_be_partial();
        logic [63:0] r;
        int c;
        int i0;
        i0 = issues;
        run_word(64'h6450_3C28_140A_0806, 64'h0A05_0302_0102_0403, 2'd0, 2'd0, 8'h0F, r, c);
        total++;
        if (r !== 64'h0000_0000_1405_0202) begin
            bad++;
            $display("FAIL be_res got=%h required 0000000014050202", r);
        end
        total++;
        if (issues - i0 != 4) begin
            bad++;
            $display("FAIL be_issues got=%0d required 4", issues - i0);
        end
        total++;
        if (c != 13) begin
            bad++;
            $display("FAIL be_latency got=%0d required 13", c);
        end
    endtask

    task automatic test_all_inactive();
        logic [63:0] r;
        int c;
        run_word(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 2'd0, 2'd1, 8'h00, r, c);
        total++;
        if (c != 5 || r !== 64'd0) begin
            bad++;
            $display("FAIL inactive_word cyc=%0d res=%h required 5 and 0", c, r);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] r;
        int c;
        run_word(64'h0000_0000_0000_0064, 64'h0000_0000_0000_0007, 2'd2, 2'd3, 8'hFF, r, c);
        total++;
        if (bus.in_rdy_o !== 1'b1 || bus.out_vld_o !== 1'b0) begin
            bad++;
            $display("FAIL b2b_rdy in_rdy=%b out_vld=%b required 1/0",
                     bus.in_rdy_o, bus.out_vld_o);
        end
        total++;
        if (r !== 64'd2) begin
            bad++;
            $display("FAIL b2b_res1 got=%h required 2", r);
        end
        run_word(64'h0000_0000_0000_0064, 64'h0000_0000_0000_0007, 2'd0, 2'd3, 8'hFF, r, c);
        total++;
        if (r !== 64'd14) begin
            bad++;
            $display("FAIL b2b_res2 got=%h required e", r);
        end
    endtask

    task automatic test_out_stall();
        int n;
        start_word(64'hFFFF_FFF9_0000_0007, 64'h0000_0002_0000_0000, 2'd3, 2'd2, 8'hFF);
        n = 0;
        while (!bus.out_vld_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            total++;
            if (bus.out_vld_o !== 1'b1 || bus.in_rdy_o !== 1'b0 ||
                bus.res_o !== 64'hFFFF_FFFF_0000_0007) begin
                bad++;
                $display("FAIL out_stall_%0d vld=%b rdy=%b res=%h required 1/0/ffffffff00000007",
                         i, bus.out_vld_o, bus.in_rdy_o, bus.res_o);
            end
            @(negedge clk);
        end
        bus.out_rdy_i = 1'b1;
        @(negedge clk);
        bus.out_rdy_i = 1'b0;
    endtask

    task automatic test_div_stall();
        int n;
        rdy_en = 1'b0;
        start_word(64'h8000_FFF9_0007_0010, 64'hFFFF_0002_0000_FFFC, 2'd1, 2'd1, 8'hFF);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (bus.div_vld_o !== 1'b1 || bus.div_op_a_o !== 64'h10 ||
                bus.div_op_b_o !== 64'hFFFF_FFFF_FFFF_FFFC || bus.div_opcode_o !== 2'd1) begin
                bad++;
                $display("FAIL div_stall_%0d vld=%b a=%h b=%h opc=%h required 1/10/fffffffffffffffc/1",
                         i, bus.div_vld_o, bus.div_op_a_o, bus.div_op_b_o, bus.div_opcode_o);
            end
            @(negedge clk);
        end
        rdy_en = 1'b1;
        n = 0;
        while (!bus.out_vld_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (bus.out_vld_o !== 1'b1 || bus.res_o !== 64'h8000_FFFD_FFFF_FFFC) begin
            bad++;
            $display("FAIL div_stall_res vld=%b res=%h required 1/8000fffdfffffffc",
                     bus.out_vld_o, bus.res_o);
        end
        bus.out_rdy_i = 1'b1;
        @(negedge clk);
        bus.out_rdy_i = 1'b0;
    endtask

    task automatic test_flush();
        logic [63:0] r;
        int c;
        int n;
        lat = 10;
        start_word(64'h6450_3C28_140A_0806, 64'h0A05_0302_0102_0403, 2'd0, 2'd0, 8'hFF);
        n = 0;
        while (!bus.div_res_rdy_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        bus.flush_i = 1'b1;
        #1;
        total++;
        if ({bus.div_flush_o, bus.in_rdy_o, bus.div_vld_o, bus.out_vld_o} !== 4'b1000) begin
            bad++;
            $display("FAIL flush_cycle got=%b required 1000",
                     {bus.div_flush_o, bus.in_rdy_o, bus.div_vld_o, bus.out_vld_o});
        end
        @(negedge clk);
        bus.flush_i = 1'b0;
        #1;
        total++;
        if (bus.in_rdy_o !== 1'b1 || bus.div_flush_o !== 1'b0) begin
            bad++;
            $display("FAIL flush_after in_rdy=%b div_flush=%b required 1/0",
                     bus.in_rdy_o, bus.div_flush_o);
        end
        n = 0;
        while (!bus.div_res_vld_i && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        total++;
        if (bus.div_res_vld_i !== 1'b1 || bus.div_res_rdy_o !== 1'b0 || bus.in_rdy_o !== 1'b1) begin
            bad++;
            $display("FAIL flush_late res_vld=%b res_rdy=%b in_rdy=%b required 1/0/1",
                     bus.div_res_vld_i, bus.div_res_rdy_o, bus.in_rdy_o);
        end
        mdl_clear = 1'b1;
        @(negedge clk);
        mdl_clear = 1'b0;
        lat = 0;
        run_word(64'h6450_3C28_140A_0806, 64'h0A05_0302_0102_0403, 2'd0, 2'd0, 8'hFF, r, c);
        total++;
        if (r !== 64'h0A10_1414_1405_0202) begin
            bad++;
            $display("FAIL flush_next_res got=%h required 0a10141414050202", r);
        end
    endtask

    initial begin
        bus.op_a_i    = '0;
        bus.op_b_i    = '0;
        bus.opcode_i  = '0;
        bus.sew_i     = '0;
        bus.be_i      = '0;
        bus.in_vld_i  = 1'b0;
        bus.flush_i   = 1'b0;
        bus.out_rdy_i = 1'b0;
        test_reset();
        test_udiv8();
        test_div16();
        test_rem32();
        test_be_partial();
        test_all_inactive();
        test_back_to_back();
        test_out_stall();
        test_div_stall();
        test_flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
